// File: rtl/data_hazard_unit_if.sv
// ID-stage hazard interface: decoded operands and controller flags in; stall/bubble and trace flags out.
// sb_valid_o exposes the scoreboard valid bits {WB, MEM, EX} for tracing.
interface data_hazard_unit_if;
    // No valid/ready handshake here: id_valid_i qualifies every ID field in the same cycle, and
    // stall_o/bubble_o answer combinationally in that cycle; flush_i overrides any stall.
    logic       id_valid_i;
    logic [4:0] id_rs1_i;
    logic [4:0] id_rs2_i;
    logic [4:0] id_rd_i;
    logic       id_detect_r1_i;
    logic       id_detect_r2_i;
    logic       id_regfile_we_i;
    logic       flush_i;
    logic       stall_o;
    logic       bubble_o;
    logic       hazard_rs1_o;
    logic       hazard_rs2_o;
    logic [2:0] sb_valid_o;

    modport master (
        output id_valid_i, id_rs1_i, id_rs2_i, id_rd_i,
        output id_detect_r1_i, id_detect_r2_i, id_regfile_we_i, flush_i,
        input  stall_o, bubble_o, hazard_rs1_o, hazard_rs2_o, sb_valid_o
    );

    modport slave (
        input  id_valid_i, id_rs1_i, id_rs2_i, id_rd_i,
        input  id_detect_r1_i, id_detect_r2_i, id_regfile_we_i, flush_i,
        output stall_o, bubble_o, hazard_rs1_o, hazard_rs2_o, sb_valid_o
    );
endinterface

// File: rtl/data_hazard_unit.sv
// Stall-based RAW hazard resolver: tracks in-flight writers in EX/MEM/WB and holds ID until they retire.
// Optional STALL_CNT_EN adds a saturating stall-cycle counter on stall_cnt_o.
module data_hazard_unit #(
    parameter int WB_FWD = 1,
    parameter int CNT_W  = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    data_hazard_unit_if.slave hz
`ifdef STALL_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt_o
`endif
);

    // With same-cycle regfile write-through, the WB entry is already visible to ID.
    localparam bit WbHazard = (WB_FWD == 0);

    logic       ex_v, mem_v, wb_v;
    logic [4:0] ex_rd, mem_rd, wb_rd;
    logic       wr;
    logic       hz1, hz2;
    logic       stall, bubble;

    always_comb begin
        wr  = hz.id_valid_i & hz.id_regfile_we_i & (hz.id_rd_i != 5'd0);
        hz1 = hz.id_valid_i & hz.id_detect_r1_i & (hz.id_rs1_i != 5'd0) &
              ((ex_v  & (ex_rd  == hz.id_rs1_i)) |
               (mem_v & (mem_rd == hz.id_rs1_i)) |
               (wb_v  & (wb_rd  == hz.id_rs1_i) & WbHazard));
        hz2 = hz.id_valid_i & hz.id_detect_r2_i & (hz.id_rs2_i != 5'd0) &
              ((ex_v  & (ex_rd  == hz.id_rs2_i)) |
               (mem_v & (mem_rd == hz.id_rs2_i)) |
               (wb_v  & (wb_rd  == hz.id_rs2_i) & WbHazard));
        stall  = (hz1 | hz2) & ~hz.flush_i;
        bubble = stall | hz.flush_i;
    end

    assign hz.hazard_rs1_o = hz1;
    assign hz.hazard_rs2_o = hz2;
    assign hz.stall_o      = stall;
    assign hz.bubble_o     = bubble;
    assign hz.sb_valid_o   = {wb_v, mem_v, ex_v};

    // MEM and WB always advance; only the EX slot sees the bubble.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ex_v   <= 1'b0;
            ex_rd  <= 5'd0;
            mem_v  <= 1'b0;
            mem_rd <= 5'd0;
            wb_v   <= 1'b0;
            wb_rd  <= 5'd0;
        end else begin
            if (bubble) begin
                ex_v  <= 1'b0;
                ex_rd <= 5'd0;
            end else begin
                ex_v  <= wr;
                ex_rd <= hz.id_rd_i;
            end
            mem_v  <= ex_v;
            mem_rd <= ex_rd;
            wb_v   <= mem_v;
            wb_rd  <= mem_rd;
        end
    end

`ifdef STALL_CNT_EN
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stall_cnt_o <= '0;
        end else if (stall && (stall_cnt_o != {CNT_W{1'b1}})) begin
            stall_cnt_o <= stall_cnt_o + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_data_hazard_unit.sv
// Directed bench running WB_FWD=1 and WB_FWD=0 instances side by side with a queue-based scoreboard.
module tb_data_hazard_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   vec_n = 0;
    logic [13:0] exp_q[$];

    always #5 clk = ~clk;

    data_hazard_unit_if if1 ();
    data_hazard_unit_if if0 ();

`ifdef STALL_CNT_EN
    logic [31:0] cnt1, cnt0;
`endif

    data_hazard_unit #(.WB_FWD(1), .CNT_W(32)) u_fwd1 (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .hz      (if1)
`ifdef STALL_CNT_EN
        ,
        .stall_cnt_o (cnt1)
`endif
    );

    data_hazard_unit #(.WB_FWD(0), .CNT_W(32)) u_fwd0 (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .hz      (if0)
`ifdef STALL_CNT_EN
        ,
        .stall_cnt_o (cnt0)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Each vector: {sb_valid[2:0], stall, bubble, hazard_rs1, hazard_rs2}; [13:7] fwd1, [6:0] fwd0.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            logic [13:0] e;
            e = exp_q.pop_front();
            check($sformatf("fwd1_vec%0d", vec_n),
                  32'({if1.sb_valid_o, if1.stall_o, if1.bubble_o, if1.hazard_rs1_o, if1.hazard_rs2_o}),
                  32'(e[13:7]));
            check($sformatf("fwd0_vec%0d", vec_n),
                  32'({if0.sb_valid_o, if0.stall_o, if0.bubble_o, if0.hazard_rs1_o, if0.hazard_rs2_o}),
                  32'(e[6:0]));
            vec_n++;
        end
    end

    task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic d1, input logic d2,
                         input logic we, input logic fl);
        if1.id_valid_i = v;  if0.id_valid_i = v;
        if1.id_rs1_i = rs1;  if0.id_rs1_i = rs1;
        if1.id_rs2_i = rs2;  if0.id_rs2_i = rs2;
        if1.id_rd_i = rd;    if0.id_rd_i = rd;
        if1.id_detect_r1_i = d1; if0.id_detect_r1_i = d1;
        if1.id_detect_r2_i = d2; if0.id_detect_r2_i = d2;
        if1.id_regfile_we_i = we; if0.id_regfile_we_i = we;
        if1.flush_i = fl;    if0.flush_i = fl;
    endtask

    task automatic step(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic d1, input logic d2,
                        input logic we, input logic fl,
                        input logic [6:0] e1, input logic [6:0] e0);
        drive(v, rs1, rs2, rd, d1, d2, we, fl);
        exp_q.push_back({e1, e0});
        @(posedge clk);
        #1;
    endtask

    task automatic bub(input logic [6:0] e1, input logic [6:0] e0);
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, e1, e0);
    endtask

    task automatic check_cnt(input string name, input logic [31:0] e1, input logic [31:0] e0);
`ifdef STALL_CNT_EN
        check({name, "_cnt_fwd1"}, cnt1, e1);
        check({name, "_cnt_fwd0"}, cnt0, e0);
`else
        if (e1 === 32'hx || e0 === 32'hx) $display("note: %s", name);
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_out_fwd1",
              32'({if1.sb_valid_o, if1.stall_o, if1.bubble_o, if1.hazard_rs1_o, if1.hazard_rs2_o}), 32'd0);
        check("reset_out_fwd0",
              32'({if0.sb_valid_o, if0.stall_o, if0.bubble_o, if0.hazard_rs1_o, if0.hazard_rs2_o}), 32'd0);
        check_cnt("reset", 32'd0, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bub(7'b000_0000, 7'b000_0000);

        // addi x1,x0,5 ; add x2,x1,x1
        step(1'b1, 5'd0, 5'd0, 5'd1, 1'b1, 1'b0, 1'b1, 1'b0, 7'b000_0000, 7'b000_0000);
        step(1'b1, 5'd1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 7'b001_1111, 7'b001_1111);
        step(1'b1, 5'd1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 7'b010_1111, 7'b010_1111);
        step(1'b1, 5'd1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 7'b100_0000, 7'b100_1111);
        bub(7'b001_0000, 7'b000_0000);
        bub(7'b010_0000, 7'b000_0000);
        bub(7'b100_0000, 7'b000_0000);
        bub(7'b000_0000, 7'b000_0000);
        check_cnt("raw_b2b", 32'd2, 32'd3);

        // addi x0,x0,1 ; add x3,x0,x0
        step(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 7'b000_0000, 7'b000_0000);
        step(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 7'b000_0000, 7'b000_0000);
        bub(7'b001_0000, 7'b001_0000);
        bub(7'b010_0000, 7'b010_0000);
        bub(7'b100_0000, 7'b100_0000);

        // lw x4,0(x1) ; jal x0 ; sw x4,0(x2)
        step(1'b1, 5'd1, 5'd0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0, 7'b000_0000, 7'b000_0000);
        step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 7'b001_0000, 7'b001_0000);
        step(1'b1, 5'd2, 5'd4, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 7'b010_1101, 7'b010_1101);
        step(1'b1, 5'd2, 5'd4, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 7'b100_0000, 7'b100_1101);
        bub(7'b000_0000, 7'b000_0000);
        check_cnt("load_store", 32'd3, 32'd5);

        // addi x5 ; add x6,x5,x0 killed by flush ; add x7,x6,x6 sees nothing from x6
        step(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 7'b000_0000, 7'b000_0000);
        step(1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 1'b1, 1'b1, 1'b1, 7'b001_0110, 7'b001_0110);
        step(1'b1, 5'd6, 5'd6, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 7'b010_0000, 7'b010_0000);
        bub(7'b101_0000, 7'b101_0000);
        bub(7'b010_0000, 7'b010_0000);
        bub(7'b100_0000, 7'b100_0000);
        check_cnt("flush", 32'd3, 32'd5);

        // addi x5,x5,1 never matches its own tag
        step(1'b1, 5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 7'b000_0000, 7'b000_0000);
        bub(7'b001_0000, 7'b001_0000);
        bub(7'b010_0000, 7'b010_0000);
        bub(7'b100_0000, 7'b100_0000);

        // addi x8 ; add x9,x8,x0 stalling, then async reset mid-cycle
        step(1'b1, 5'd0, 5'd0, 5'd8, 1'b1, 1'b0, 1'b1, 1'b0, 7'b000_0000, 7'b000_0000);
        step(1'b1, 5'd8, 5'd0, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 7'b001_1110, 7'b001_1110);
        exp_q.push_back({7'b010_1110, 7'b010_1110});
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_fwd1",
              32'({if1.sb_valid_o, if1.stall_o, if1.bubble_o, if1.hazard_rs1_o, if1.hazard_rs2_o}), 32'd0);
        check("async_rst_fwd0",
              32'({if0.sb_valid_o, if0.stall_o, if0.bubble_o, if0.hazard_rs1_o, if0.hazard_rs2_o}), 32'd0);
        check_cnt("async_rst", 32'd0, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b1, 5'd8, 5'd0, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 7'b000_0000, 7'b000_0000);
        bub(7'b001_0000, 7'b001_0000);
        check_cnt("post_rst", 32'd0, 32'd0);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
